sdp_ram_reader: RTL and testbench

SDP_RAM_READER -- requirements
Module: sdp_ram_reader

---
 rtl/sdp_ram_reader.sv | 134 +++++++++++++
 tb/tb_sdp_ram_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_reader.sv
// Burst reader for a simple-dual-port RAM: issues len sequential reads from
// baseAdr (wrapping) and streams the returned words through a 2-entry FIFO.
module sdp_ram_reader #(
  parameter int WIDTH     = 8,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 start,
  input  logic [DEPTH_LOG-1:0] baseAdr,
  input  logic [DEPTH_LOG:0]   len,
  output logic                 rdEn,
  output logic [DEPTH_LOG-1:0] rdAdr,
  input  logic [WIDTH-1:0]     rdDat,
  output logic [WIDTH-1:0]     outDat,
  output logic                 outVld,
  input  logic                 outRdy,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t               r_state;
  state_t               w_stateNxt;
  logic [DEPTH_LOG-1:0] r_adr;
  logic [DEPTH_LOG:0]   r_rdRem;
  logic [DEPTH_LOG:0]   r_outRem;
  logic                 r_inFlt;
  logic [1:0]           r_cnt;
  logic [WIDTH-1:0]     r_head;
  logic [WIDTH-1:0]     r_tail;
  logic                 r_busy;
  logic                 r_done;

  logic                 w_pop;
  logic                 w_push;
  logic [2:0]           w_level;
  logic                 w_accept;
  logic                 w_zeroReq;
  logic                 w_lastRd;
  logic                 w_lastPop;

  localparam logic [DEPTH_LOG:0] ONE = (DEPTH_LOG+1)'(1);

  assign outVld  = (r_cnt != 2'd0);
  assign outDat  = r_head;
  assign rdAdr   = r_adr;
  assign busy    = r_busy;
  assign done    = r_done;

  assign w_pop   = outVld & outRdy;
  assign w_push  = r_inFlt;
  // Words that will occupy the FIFO once everything already requested lands.
  assign w_level = {1'b0, r_cnt} + {2'b00, r_inFlt} - {2'b00, w_pop};

  assign w_accept  = (r_state == IDLE) && start && (len != '0);
  assign w_zeroReq = (r_state == IDLE) && start && (len == '0);
  assign w_lastRd  = rdEn && (r_rdRem == ONE);
  assign w_lastPop = (r_state == DRAIN) && w_pop && (r_outRem == ONE);

  always_comb begin
    w_stateNxt = r_state;
    rdEn       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_stateNxt = READ;
      end
      READ: begin
        rdEn = (w_level < 3'd2);
        if (w_lastRd) w_stateNxt = DRAIN;
      end
      DRAIN: begin
        if (w_lastPop) w_stateNxt = IDLE;
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state  <= IDLE;
      r_adr    <= '0;
      r_rdRem  <= '0;
      r_outRem <= '0;
      r_inFlt  <= 1'b0;
      r_cnt    <= '0;
      r_head   <= '0;
      r_tail   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_inFlt <= rdEn;
      r_done  <= w_zeroReq | w_lastPop;
      // Busy covers the done cycle of a real burst, hence the w_lastPop term.
      r_busy  <= (w_stateNxt != IDLE) | w_lastPop;

      if (w_accept) begin
        r_adr    <= baseAdr;
        r_rdRem  <= len;
        r_outRem <= len;
      end else begin
        if (rdEn) begin
          r_adr   <= r_adr + 1'b1;
          r_rdRem <= r_rdRem - ONE;
        end
        if (w_pop) r_outRem <= r_outRem - ONE;
      end

      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= rdDat;
          else               r_tail <= rdDat;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= rdDat;
          end else begin
            r_head <= r_tail;
            r_tail <= rdDat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdp_ram_reader.sv
// Directed + randomized bursts against a queue-based expectation of the
// address/data sequence, latency and handshake behaviour.
module tb_sdp_ram_reader;

  localparam int W  = 8;
  localparam int DL = 4;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rstN;
  logic          start;
  logic [DL-1:0] baseAdr;
  logic [DL:0]   len;
  logic          rdEn;
  logic [DL-1:0] rdAdr;
  logic [W-1:0]  rdDat;
  logic [W-1:0]  outDat;
  logic          outVld;
  logic          outRdy;
  logic          busy;
  logic          done;

  logic [W-1:0]  mem [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdp_ram_reader #(.WIDTH(W), .DEPTH_LOG(DL)) dut (
    .clk     (clk),
    .rstN    (rstN),
    .start   (start),
    .baseAdr (baseAdr),
    .len     (len),
    .rdEn    (rdEn),
    .rdAdr   (rdAdr),
    .rdDat   (rdDat),
    .outDat  (outDat),
    .outVld  (outVld),
    .outRdy  (outRdy),
    .busy    (busy),
    .done    (done)
  );

  // Synchronous RAM: data appears the cycle after rdEn.
  always @(posedge clk) if (rdEn) rdDat <= mem[rdAdr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rdEn"},   32'(rdEn),   0);
    chk({tag, "_rdAdr"},  32'(rdAdr),  0);
    chk({tag, "_outDat"}, 32'(outDat), 0);
    chk({tag, "_outVld"}, 32'(outVld), 0);
    chk({tag, "_busy"},   32'(busy),   0);
    chk({tag, "_done"},   32'(done),   0);
  endtask

  // mode 0: outRdy always 1; mode 1: outRdy low in cycles 3-10; mode 2: random.
  // extra_cyc>0 issues a second start pulse in that cycle.
  task automatic run_burst(input int base, input int ln, input int mode,
                           input int extra_cyc, input string nm);
    int         adrQ[$];
    logic [W-1:0] datQ[$];
    int         xcyc[$];
    int         done_cnt  = 0;
    int         done_cyc  = -1;
    int         busy_cnt  = 0;
    int         issued    = 0;
    int         xfer      = 0;
    int         first_rd  = -1;
    int         first_vld = -1;
    int         post      = 0;
    bit         stall     = 0;
    logic [W-1:0] prev_dat = '0;

    @(posedge clk); #1;
    start   = 1'b1;
    baseAdr = DL'(base);
    len     = (DL+1)'(ln);
    outRdy  = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;

    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      start   = (c == extra_cyc);
      baseAdr = DL'($urandom_range(0, N-1));
      len     = (DL+1)'($urandom_range(0, N));
      if (mode == 0)      outRdy = 1'b1;
      else if (mode == 1) outRdy = !(c >= 3 && c <= 10);
      else                outRdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (stall) begin
        chk({nm, "_vld_held"}, 32'(outVld), 1);
        chk({nm, "_dat_stable"}, 32'(outDat), 32'(prev_dat));
      end
      stall    = outVld && !outRdy;
      prev_dat = outDat;
      if (rdEn) begin
        adrQ.push_back(int'(rdAdr));
        issued++;
        if (first_rd < 0) first_rd = c;
      end
      if (outVld && first_vld < 0) first_vld = c;
      if (outVld && outRdy) begin
        datQ.push_back(outDat);
        xcyc.push_back(c);
        xfer++;
      end
      chk({nm, "_outstanding_le2"}, 32'(issued - xfer <= 2), 1);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0) post++;
      if (post > 3) break;
    end

    chk({nm, "_nreads"}, adrQ.size(), ln);
    for (int i = 0; i < adrQ.size() && i < ln; i++)
      chk({nm, "_adr"}, adrQ[i], (base + i) % N);
    chk({nm, "_nwords"}, datQ.size(), ln);
    for (int i = 0; i < datQ.size() && i < ln; i++)
      chk({nm, "_dat"}, 32'(datQ[i]), 32'(mem[(base + i) % N]));
    chk({nm, "_done_cnt"}, done_cnt, 1);
    if (ln == 0) begin
      chk({nm, "_done_cyc"}, done_cyc, 1);
      chk({nm, "_busy_cnt"}, busy_cnt, 0);
    end else begin
      chk({nm, "_first_rd"}, first_rd, 1);
      chk({nm, "_first_vld"}, first_vld, 3);
      chk({nm, "_busy_cnt"}, busy_cnt, done_cyc);
      if (xcyc.size() > 0) chk({nm, "_done_after_last"}, done_cyc, xcyc[$] + 1);
      if (mode == 0) begin
        chk({nm, "_done_cyc"}, done_cyc, ln + 3);
        for (int i = 0; i < xcyc.size(); i++)
          chk({nm, "_xfer_cyc"}, xcyc[i], 3 + i);
      end
    end
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < N; i++) mem[i] = W'($urandom);
  endtask

  initial begin
    int dcnt;
    rstN = 1'b0; start = 1'b0; baseAdr = '0; len = '0; outRdy = 1'b0;
    for (int i = 0; i < N; i++) mem[i] = W'(i + 16);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rstN = 1'b1;

    run_burst(2, 4, 0, 0, "basic");
    randomize_mem();
    run_burst(14, 4, 0, 0, "wrap");
    run_burst($urandom_range(0, N-1), 4, 1, 0, "stall");
    run_burst($urandom_range(0, N-1), 0, 0, 0, "zero_len");
    run_burst($urandom_range(0, N-1), 4, 0, 2, "restart_ignored");
    run_burst($urandom_range(0, N-1), 16, 2, 0, "full");

    // Mid-burst reset: rstN low for cycle 5 only.
    @(posedge clk); #1;
    start = 1'b1; baseAdr = 4'd3; len = 5'd16; outRdy = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 5) rstN = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    rstN = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    dcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("midreset_no_done", dcnt, 0);
    run_burst($urandom_range(0, N-1), 2, 0, 0, "post_reset");

    for (int k = 0; k < 5; k++) begin
      randomize_mem();
      run_burst($urandom_range(0, N-1), $urandom_range(0, N), 2, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
